// File: rtl/int_pkg.sv
// Shared types and constants for the interrupt controller: source ids, dispatch states, vector layout.
package int_pkg;

  typedef enum logic [2:0] {
    INT_VBLANK,
    INT_STAT,
    INT_TIMER,
    INT_SERIAL,
    INT_JOYPAD
  } int_src_e;

  typedef enum logic [1:0] {
    DS_IDLE,
    DS_PUSH,
    DS_VECTOR
  } dispatch_state_e;

  localparam logic [7:0] INT_VEC_BASE   = 8'h40;
  localparam logic [7:0] INT_VEC_STRIDE = 8'h08;
  localparam logic [2:0] IF_UNUSED      = 3'b111;

  // Vector low byte for a source index: 0x40, 0x48, 0x50, ...
  function automatic logic [7:0] vec_of(input logic [2:0] idx);
    return INT_VEC_BASE + INT_VEC_STRIDE * {5'd0, idx};
  endfunction

endpackage

// File: rtl/int_priority_enc.sv
// Lowest-index-wins priority encoder over the pending-interrupt mask.
module int_priority_enc #(
  parameter int NUM_SRC = 5
) (
  input  logic [NUM_SRC-1:0] mask,
  output logic               valid,
  output logic [2:0]         index
);

  always_comb begin
    valid = 1'b0;
    index = 3'd0;
    // Scan high to low so the last hit, the lowest set bit, is what remains.
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (mask[i]) begin
        valid = 1'b1;
        index = 3'(i);
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// IF/IE registers, request/wake generation and CPU dispatch handshake (start -> push -> vector).
// Optional macro INT_DISPATCH_CANCEL_EN: re-select the source at commit instead of freezing it at start.
module interrupt_controller
  import int_pkg::*;
#(
  parameter int NUM_SRC  = 5,
  parameter int IE_WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cpu_en,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               reg_sel,
  input  logic [7:0]         wdata,
  input  logic               write,
  output logic [7:0]         rdata,
  input  logic               ime,
  output logic               int_req,
  output logic               wake,
  input  logic               ack_start,
  input  logic               ack_commit,
  output logic [7:0]         int_vector,
  output logic               int_busy
);

  logic [NUM_SRC-1:0]  if_q;
  logic [IE_WIDTH-1:0] ie_q;
  logic [NUM_SRC-1:0]  pend;
  logic                pend_vld;
  logic [2:0]          pend_idx;
  logic                commit_vld;
  logic [2:0]          commit_idx;
  logic [NUM_SRC-1:0]  clr_mask;
  logic                commit;
  dispatch_state_e     state, state_nxt;

  assign pend = ie_q[NUM_SRC-1:0] & if_q;

  int_priority_enc #(.NUM_SRC(NUM_SRC)) u_prio (
    .mask  (pend),
    .valid (pend_vld),
    .index (pend_idx)
  );

  assign int_req  = ime & (|pend);
  assign wake     = |pend;
  assign int_busy = (state != DS_IDLE);

  always_comb begin
    rdata = 8'hFF;
    if (reg_sel) begin
      rdata = '0;
      rdata[IE_WIDTH-1:0] = ie_q;
    end else begin
      rdata[NUM_SRC-1:0] = if_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= DS_IDLE;
    else if (cpu_en) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    case (state)
      DS_IDLE:   if (ack_start) state_nxt = DS_PUSH;
      DS_PUSH:   if (ack_commit) begin
                   state_nxt = DS_VECTOR;
                   commit    = 1'b1;
                 end
      DS_VECTOR: state_nxt = DS_IDLE;
      default:   state_nxt = DS_IDLE;
    endcase
  end

`ifdef INT_DISPATCH_CANCEL_EN
  // Selection follows live IE&IF up to the commit cycle.
  assign commit_vld = pend_vld;
  assign commit_idx = pend_idx;
`else
  logic       sel_vld_q;
  logic [2:0] sel_q;
  logic       latch_sel;

  assign latch_sel = (state == DS_IDLE) && ack_start;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sel_q     <= 3'd0;
      sel_vld_q <= 1'b0;
    end else if (cpu_en && latch_sel) begin
      sel_q     <= pend_idx;
      sel_vld_q <= pend_vld;
    end
  end

  assign commit_vld = sel_vld_q;
  assign commit_idx = sel_q;
`endif

  always_comb begin
    clr_mask = '0;
    if (commit && commit_vld) clr_mask[commit_idx] = 1'b1;
  end

  // Source pulses are OR-ed last so they win over both clear and write.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      if_q       <= '0;
      ie_q       <= '0;
      int_vector <= 8'h00;
    end else if (cpu_en) begin
      if (write && !reg_sel) if_q <= wdata[NUM_SRC-1:0] | irq_src;
      else                   if_q <= (if_q & ~clr_mask) | irq_src;
      if (write && reg_sel) ie_q <= wdata[IE_WIDTH-1:0];
      if (commit) int_vector <= commit_vld ? vec_of(commit_idx) : 8'h00;
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed scenarios plus randomized traffic checked against a behavioural model of IF/IE/dispatch.
module tb_interrupt_controller;

  logic       clk = 1'b0;
  logic       reset_n, cpu_en, reg_sel, write, ime, ack_start, ack_commit;
  logic [4:0] irq_src;
  logic [7:0] wdata, rdata, int_vector;
  logic       int_req, wake, int_busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_if, m_ie, m_phase, m_sel, m_vec;

  always #5 clk = ~clk;

  interrupt_controller dut (
    .clk(clk), .reset_n(reset_n), .cpu_en(cpu_en), .irq_src(irq_src),
    .reg_sel(reg_sel), .wdata(wdata), .write(write), .rdata(rdata),
    .ime(ime), .int_req(int_req), .wake(wake), .ack_start(ack_start),
    .ack_commit(ack_commit), .int_vector(int_vector), .int_busy(int_busy)
  );

  function automatic int lowbit(input int x);
    if (x == 0) return -1;
    return $clog2(x & -x);
  endfunction

  function automatic void model_step();
    int clr, s, nif;
    if (!reset_n) begin
      m_if = 0; m_ie = 0; m_phase = 0; m_sel = -1; m_vec = 0;
      return;
    end
    if (!cpu_en) return;
    clr = 0;
    case (m_phase)
      0: if (ack_start) begin
           m_sel = lowbit(m_ie & m_if & 31);
           m_phase = 1;
         end
      1: if (ack_commit) begin
`ifdef INT_DISPATCH_CANCEL_EN
           s = lowbit(m_ie & m_if & 31);
`else
           s = m_sel;
`endif
           clr   = (s >= 0) ? (1 << s) : 0;
           m_vec = (s >= 0) ? 64 + 8 * s : 0;
           m_phase = 2;
         end
      default: m_phase = 0;
    endcase
    nif = (write && !reg_sel) ? (int'(wdata) & 31) : (m_if & ~clr);
    nif = nif | int'(irq_src);
    if (write && reg_sel) m_ie = int'(wdata);
    m_if = nif;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic wr(input logic sel, input logic [7:0] d);
    reg_sel = sel; wdata = d; write = 1'b1;
    tick();
    write = 1'b0;
  endtask

  task automatic rd(input logic sel, output logic [7:0] v);
    reg_sel = sel;
    #1;
    v = rdata;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    ime = 1'b1;
    wr(1'b0, 8'h1F);
    wr(1'b1, 8'h1F);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    rd(1'b0, v);
    n_checks++; if (v !== 8'hE0) begin n_fail++; $display("FAIL reset_if got %h want e0", v); end
    rd(1'b1, v);
    n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL reset_ie got %h want 00", v); end
    n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", int_req); end
    n_checks++; if (int_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", int_busy); end
    n_checks++; if (int_vector !== 8'h00) begin n_fail++; $display("FAIL reset_vec got %h want 00", int_vector); end
  endtask

  task automatic test_single();
    logic [7:0] v;
    wr(1'b1, 8'h04);
    ime = 1'b1;
    irq_src = 5'b00100;
    tick();
    irq_src = 5'b0;
    rd(1'b0, v);
    n_checks++; if (v !== 8'hE4) begin n_fail++; $display("FAIL single_if got %h want e4", v); end
    n_checks++; if (int_req !== 1'b1) begin n_fail++; $display("FAIL single_req got %b want 1", int_req); end
    ack_start = 1'b1; tick(); ack_start = 1'b0;
    n_checks++; if (int_busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got %b want 1", int_busy); end
    ack_commit = 1'b1; tick(); ack_commit = 1'b0;
    n_checks++; if (int_vector !== 8'h50) begin n_fail++; $display("FAIL single_vec got %h want 50", int_vector); end
    rd(1'b0, v);
    n_checks++; if (v !== 8'hE0) begin n_fail++; $display("FAIL single_if_clr got %h want e0", v); end
    n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL single_req_clr got %b want 0", int_req); end
    tick();
    n_checks++; if (int_busy !== 1'b0) begin n_fail++; $display("FAIL single_idle got %b want 0", int_busy); end
  endtask

  task automatic test_priority();
    logic [7:0] v, want;
    wr(1'b1, 8'h1F);
    wr(1'b0, 8'h1F);
    ime = 1'b1;
    for (int k = 0; k < 5; k++) begin
      ack_start = 1'b1; tick(); ack_start = 1'b0;
      ack_commit = 1'b1; tick(); ack_commit = 1'b0;
      want = 8'h40 + 8'(8 * k);
      n_checks++; if (int_vector !== want) begin n_fail++; $display("FAIL prio_vec%0d got %h want %h", k, int_vector, want); end
      tick();
    end
    rd(1'b0, v);
    n_checks++; if (v !== 8'hE0) begin n_fail++; $display("FAIL prio_if_empty got %h want e0", v); end
  endtask

  task automatic test_collision();
    logic [7:0] v;
    irq_src = 5'b00100;
    wr(1'b0, 8'h00);
    irq_src = 5'b0;
    rd(1'b0, v);
    n_checks++; if (v !== 8'hE4) begin n_fail++; $display("FAIL coll_write got %h want e4", v); end
    ack_start = 1'b1; tick(); ack_start = 1'b0;
    ack_commit = 1'b1; irq_src = 5'b00100; tick(); ack_commit = 1'b0; irq_src = 5'b0;
    n_checks++; if (int_vector !== 8'h50) begin n_fail++; $display("FAIL coll_vec got %h want 50", int_vector); end
    rd(1'b0, v);
    n_checks++; if (v !== 8'hE4) begin n_fail++; $display("FAIL coll_clear got %h want e4", v); end
    tick();
    wr(1'b0, 8'h00);
  endtask

  task automatic test_wake();
    logic [7:0] v;
    ime = 1'b0;
    wr(1'b1, 8'h01);
    irq_src = 5'b00001; tick(); irq_src = 5'b0;
    n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL wake_req got %b want 0", int_req); end
    n_checks++; if (wake !== 1'b1) begin n_fail++; $display("FAIL wake_wake got %b want 1", wake); end
    repeat (3) tick();
    n_checks++; if (int_busy !== 1'b0) begin n_fail++; $display("FAIL wake_busy got %b want 0", int_busy); end
    rd(1'b0, v);
    n_checks++; if (v !== 8'hE1) begin n_fail++; $display("FAIL wake_if got %h want e1", v); end
  endtask

  task automatic test_cancel();
    logic [7:0] v, want_vec, want_if;
`ifdef INT_DISPATCH_CANCEL_EN
    want_vec = 8'h00; want_if = 8'hE1;
`else
    want_vec = 8'h40; want_if = 8'hE0;
`endif
    ime = 1'b1;
    ack_start = 1'b1; tick(); ack_start = 1'b0;
    wr(1'b1, 8'h00);
    ack_commit = 1'b1; tick(); ack_commit = 1'b0;
    n_checks++; if (int_vector !== want_vec) begin n_fail++; $display("FAIL cancel_vec got %h want %h", int_vector, want_vec); end
    rd(1'b0, v);
    n_checks++; if (v !== want_if) begin n_fail++; $display("FAIL cancel_if got %h want %h", v, want_if); end
    tick();
    wr(1'b1, 8'h01);
    wr(1'b0, 8'h01);
    ack_start = 1'b1; tick(); ack_start = 1'b0;
    n_checks++; if (int_busy !== 1'b1) begin n_fail++; $display("FAIL midpush_busy got %b want 1", int_busy); end
    reset_n = 1'b0; ack_commit = 1'b1; tick(); reset_n = 1'b1; ack_commit = 1'b0;
    n_checks++; if (int_busy !== 1'b0) begin n_fail++; $display("FAIL midpush_idle got %b want 0", int_busy); end
    n_checks++; if (int_vector !== 8'h00) begin n_fail++; $display("FAIL midpush_vec got %h want 00", int_vector); end
  endtask

  task automatic test_random();
    logic [7:0] exp_rd;
    logic       exp_pend;
    for (int i = 0; i < 3000; i++) begin
      cpu_en     = ($urandom_range(0, 7) != 0);
      reset_n    = ($urandom_range(0, 199) != 0);
      irq_src    = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'b0;
      reg_sel    = 1'($urandom);
      write      = ($urandom_range(0, 5) == 0);
      wdata      = 8'($urandom);
      ime        = 1'($urandom);
      ack_start  = ($urandom_range(0, 5) == 0);
      ack_commit = ($urandom_range(0, 3) == 0);
      #1;
      exp_rd   = reg_sel ? 8'(m_ie) : (8'hE0 | 8'(m_if));
      exp_pend = ((m_ie & m_if & 31) != 0);
      n_checks++; if (rdata !== exp_rd) begin n_fail++; $display("FAIL rnd_rdata cyc %0d got %h want %h", i, rdata, exp_rd); end
      n_checks++; if (int_req !== (exp_pend & ime)) begin n_fail++; $display("FAIL rnd_req cyc %0d got %b want %b", i, int_req, exp_pend & ime); end
      n_checks++; if (wake !== exp_pend) begin n_fail++; $display("FAIL rnd_wake cyc %0d got %b want %b", i, wake, exp_pend); end
      n_checks++; if (int_busy !== (m_phase != 0)) begin n_fail++; $display("FAIL rnd_busy cyc %0d got %b want %b", i, int_busy, m_phase != 0); end
      n_checks++; if (int_vector !== 8'(m_vec)) begin n_fail++; $display("FAIL rnd_vec cyc %0d got %h want %h", i, int_vector, 8'(m_vec)); end
      tick();
    end
  endtask

  initial begin
    reset_n = 1'b0; cpu_en = 1'b1; irq_src = 5'b0; reg_sel = 1'b0; wdata = 8'h00;
    write = 1'b0; ime = 1'b0; ack_start = 1'b0; ack_commit = 1'b0;
    m_if = 0; m_ie = 0; m_phase = 0; m_sel = -1; m_vec = 0;
    tick();
    tick();
    reset_n = 1'b1;
    test_reset();
    test_single();
    test_priority();
    test_collision();
    test_wake();
    test_cancel();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
